// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_align_unit
//  Description : RV32 load path: byte-address generation, fixed-latency word
//                read, and byte/half/word extraction with sign/zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align_unit #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [31:0]           rs1,
    input  logic [31:0]           imm,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           rd_data,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
    localparam logic [3:0] c_CNT_INIT = 4'(READ_LATENCY - 1);

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic [31:0] w_byte_addr;
    logic        w_illegal;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_result;
    logic        w_unused_addr;

    assign w_byte_addr   = rs1 + imm;
    // Upper address bits simply wrap into the memory space.
    assign w_unused_addr = &{1'b0, w_byte_addr};

    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (funct3)
            c_F3_LB, c_F3_LBU: w_misaligned = 1'b0;
            c_F3_LH, c_F3_LHU: w_misaligned = w_byte_addr[0];
            c_F3_LW:           w_misaligned = |w_byte_addr[1:0];
            default:           w_illegal    = 1'b1;
        endcase
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            c_F3_LB:  w_result = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: w_result = {24'd0, w_byte};
            c_F3_LH:  w_result = {{16{w_half[15]}}, w_half};
            c_F3_LHU: w_result = {16'd0, w_half};
            default:  w_result = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 4'd0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            rd_data     <= 32'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_off    <= w_byte_addr[1:0];
                        busy     <= 1'b1;
                        if (w_illegal || w_misaligned) begin
                            r_state <= c_ST_DONE;
                            rd_data <= 32'd0;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_state     <= c_ST_READ;
                            r_cnt       <= c_CNT_INIT;
                            mem_address <= w_byte_addr[ADDR_WIDTH+1:2];
                            mem_read    <= 1'b1;
                            err         <= 1'b0;
                        end
                    end
                end
                c_ST_READ: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= c_ST_DONE;
                        mem_read <= 1'b0;
                        rd_data  <= w_result;
                        done     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    mem_read <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_align_unit
//  Description : Directed self-checking bench for load_align_unit (L = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_align_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [9:0]  mem_address;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    load_align_unit #(
        .ADDR_WIDTH   (10),
        .READ_LATENCY (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .funct3      (funct3),
        .rs1         (rs1),
        .imm         (imm),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .rd_data     (rd_data),
        .done        (done),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a legal load at a negedge and check every cycle through DONE.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] r1,
                            input logic [31:0] im, input logic [31:0] word,
                            input logic [9:0] exp_addr, input logic [31:0] exp_rd);
        funct3 = f3; rs1 = r1; imm = im; mem_rdata = word; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".c1_mem_read"}, 32'(mem_read), 32'd1);
        check({tag, ".c1_addr"},     32'(mem_address), 32'(exp_addr));
        check({tag, ".c1_busy"},     32'(busy), 32'd1);
        check({tag, ".c1_err"},      32'(err), 32'd0);
        check({tag, ".c1_done"},     32'(done), 32'd0);
        @(negedge clk);
        check({tag, ".c2_mem_read"}, 32'(mem_read), 32'd1);
        check({tag, ".c2_done"},     32'(done), 32'd0);
        @(negedge clk);
        check({tag, ".c3_done"},     32'(done), 32'd1);
        check({tag, ".c3_mem_read"}, 32'(mem_read), 32'd0);
        check({tag, ".c3_err"},      32'(err), 32'd0);
        check({tag, ".c3_rd_data"},  rd_data, exp_rd);
        @(negedge clk);
        check({tag, ".c4_done"},     32'(done), 32'd0);
        check({tag, ".c4_busy"},     32'(busy), 32'd0);
        check({tag, ".c4_rd_hold"},  rd_data, exp_rd);
    endtask

    // Issue a request that must be rejected without touching memory.
    task automatic run_err(input string tag, input logic [2:0] f3, input logic [31:0] r1,
                           input logic [31:0] im);
        funct3 = f3; rs1 = r1; imm = im; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done"},     32'(done), 32'd1);
        check({tag, ".err"},      32'(err), 32'd1);
        check({tag, ".rd_data"},  rd_data, 32'd0);
        check({tag, ".mem_read"}, 32'(mem_read), 32'd0);
        @(negedge clk);
        check({tag, ".done_end"}, 32'(done), 32'd0);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n_done;
        rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; rs1 = 32'd0; imm = 32'd0; mem_rdata = 32'd0;
        #12;
        check("rst.mem_address", 32'(mem_address), 32'd0);
        check("rst.mem_read",    32'(mem_read), 32'd0);
        check("rst.rd_data",     rd_data, 32'd0);
        check("rst.done",        32'(done), 32'd0);
        check("rst.err",         32'(err), 32'd0);
        check("rst.busy",        32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_load("lb",   3'b000, 32'h100, 32'd3, 32'h80FF1234, 10'h040, 32'hFFFFFF80);
        run_load("lbu",  3'b100, 32'h100, 32'd3, 32'h80FF1234, 10'h040, 32'h00000080);
        run_load("lh",   3'b001, 32'h100, 32'd2, 32'h80017FFF, 10'h040, 32'hFFFF8001);
        run_load("lhu",  3'b101, 32'h100, 32'd2, 32'h80017FFF, 10'h040, 32'h00008001);
        run_load("lw",   3'b010, 32'h100, 32'd4, 32'hDEADBEEF, 10'h041, 32'hDEADBEEF);
        run_load("lh0",  3'b001, 32'h100, 32'd0, 32'h80017FFF, 10'h040, 32'h00007FFF);
        run_load("lb1",  3'b000, 32'h100, 32'd1, 32'h80FF1234, 10'h040, 32'h00000012);
        run_load("lbwrap", 3'b000, 32'hFFFFF000, 32'h10, 32'h0000007F, 10'h004, 32'h0000007F);
        run_load("lhuneg", 3'b101, 32'h200, 32'hFFFFFFFE, 32'h12345678, 10'h07F, 32'h00001234);

        run_err("lw_mis",  3'b010, 32'h1000, 32'd1);
        run_err("lh_mis",  3'b001, 32'h100, 32'd1);
        run_err("f3_011",  3'b011, 32'h100, 32'd0);
        run_load("after_err", 3'b010, 32'h100, 32'd4, 32'hCAFEF00D, 10'h041, 32'hCAFEF00D);

        // Second start during READ must be dropped entirely.
        funct3 = 3'b010; rs1 = 32'h100; imm = 32'd8; mem_rdata = 32'h01234567; start = 1'b1;
        @(negedge clk);
        rs1 = 32'h300; imm = 32'd0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) check("busy_start.addr", 32'(mem_address), 32'h042);
            if (i == 1) start = 1'b0;
            if (done) n_done++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start.done_count", 32'(n_done), 32'd1);
        check("busy_start.rd_data", rd_data, 32'h01234567);

        // Asynchronous reset in the second READ cycle.
        funct3 = 3'b000; rs1 = 32'h100; imm = 32'd3; mem_rdata = 32'h80FF1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid.pre_mem_read", 32'(mem_read), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid.mem_read", 32'(mem_read), 32'd0);
        check("rst_mid.busy",     32'(busy), 32'd0);
        check("rst_mid.rd_data",  rd_data, 32'd0);
        check("rst_mid.done",     32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("rst_mid.no_done", 32'(n_done), 32'd0);
        check("rst_mid.idle",    32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
